// File: rtl/mem_access_stage.sv
// mem_access_stage: MIPS MEM stage with word-addressed data memory, fixed-latency access stall and WB registers
//   Parameters: DEPTH (memory words, power of two), MEM_LATENCY (stall cycles per access, 0..15)
//   Inputs : clk, rst (sync, active-high), in_valid, MemRead, MemWrite, MemtoReg, RegWrite,
//            ALUResult[31:0] (byte address / ALU value), storeData[31:0], writeReg[4:0]
//   Outputs: stall (combinational), wb_valid, wb_MemtoReg, wb_RegWrite, wb_readData[31:0],
//            wb_ALUResult[31:0], wb_writeReg[4:0], misaligned
//   Option : MEM_MISALIGN_TRAP_EN traps unaligned memops as single-cycle faults with no memory access
module mem_access_stage #(
  parameter int DEPTH       = 256,
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemtoReg,
  input  logic        RegWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] storeData,
  input  logic [4:0]  writeReg,
  output logic        stall,
  output logic        wb_valid,
  output logic        wb_MemtoReg,
  output logic        wb_RegWrite,
  output logic [31:0] wb_readData,
  output logic [31:0] wb_ALUResult,
  output logic [4:0]  wb_writeReg,
  output logic        misaligned
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] idx;
  logic        memop, mis, complete, we;
  logic [31:0] rdata;
  logic        unused_ok;
  assign memop = in_valid & (MemRead | MemWrite);
  assign idx   = ALUResult[AW+1:2];
`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = memop & (ALUResult[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif
  // IDLE stalls on a fresh access; WAIT releases once the countdown has reached zero
  assign stall    = (state_q == WAIT) ? (cnt_q != 4'd0) : (memop & ~mis & (MEM_LATENCY != 0));
  assign complete = in_valid & ~stall;
  assign we       = complete & MemWrite & ~mis;
  // read+write together counts as a write, so no load data is returned
  assign rdata    = (complete & MemRead & ~MemWrite & ~mis) ? mem[idx] : 32'd0;
  assign unused_ok = &{1'b0, ALUResult[31:AW+2], ALUResult[1:0]};
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      wb_valid     <= 1'b0;
      wb_MemtoReg  <= 1'b0;
      wb_RegWrite  <= 1'b0;
      wb_readData  <= 32'd0;
      wb_ALUResult <= 32'd0;
      wb_writeReg  <= 5'd0;
      misaligned   <= 1'b0;
    end else begin
      state_q      <= stall ? WAIT : IDLE;
      cnt_q        <= stall ? ((state_q == IDLE) ? 4'(MEM_LATENCY - 1) : cnt_q - 4'd1) : 4'd0;
      wb_valid     <= complete;
      wb_MemtoReg  <= complete & MemtoReg;
      wb_RegWrite  <= complete & RegWrite & ~mis;
      wb_readData  <= rdata;
      wb_ALUResult <= complete ? ALUResult : 32'd0;
      wb_writeReg  <= complete ? writeReg : 5'd0;
      misaligned   <= complete & mis;
    end
  end
  // memory contents survive reset; a reset edge abandons the pending store
  always_ff @(posedge clk) begin
    if (!rst && we) mem[idx] <= storeData;
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed self-checking bench for mem_access_stage
module tb_mem_access_stage;
  localparam int LAT = 2;
  logic        clk = 1'b0;
  logic        rst, in_valid, MemRead, MemWrite, MemtoReg, RegWrite;
  logic [31:0] ALUResult, storeData;
  logic [4:0]  writeReg;
  logic        stall, wb_valid, wb_MemtoReg, wb_RegWrite, misaligned;
  logic [31:0] wb_readData, wb_ALUResult;
  logic [4:0]  wb_writeReg;
  int          errs = 0;
  int          checks = 0;
  mem_access_stage #(.DEPTH(256), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUResult(ALUResult), .storeData(storeData),
    .writeReg(writeReg), .stall(stall), .wb_valid(wb_valid), .wb_MemtoReg(wb_MemtoReg),
    .wb_RegWrite(wb_RegWrite), .wb_readData(wb_readData), .wb_ALUResult(wb_ALUResult),
    .wb_writeReg(wb_writeReg), .misaligned(misaligned)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic rd, input logic wr, input logic m2r,
                       input logic rw, input logic [31:0] alu, input logic [31:0] sd,
                       input logic [4:0] wreg);
    in_valid = v; MemRead = rd; MemWrite = wr; MemtoReg = m2r;
    RegWrite = rw; ALUResult = alu; storeData = sd; writeReg = wreg;
    #1;
  endtask
  task automatic idle();
    drive(0, 0, 0, 0, 0, 32'd0, 32'd0, 5'd0);
  endtask
  // inputs already driven: expect LAT stall cycles with bubbles, then completion
  task automatic access(input string tag);
    for (int i = 0; i < LAT; i++) begin
      check({tag, "_stall"}, stall, 1);
      tick();
      check({tag, "_bubble"}, wb_valid, 0);
    end
    check({tag, "_release"}, stall, 0);
    tick();
    check({tag, "_done"}, wb_valid, 1);
  endtask
  initial begin
    rst = 1'b1;
    drive(1, 1, 0, 1, 1, 32'h10, 32'd0, 5'd3);
    tick();
    tick();
    check("rst_valid", wb_valid, 0);
    check("rst_rw", wb_RegWrite, 0);
    check("rst_m2r", wb_MemtoReg, 0);
    check("rst_rdata", wb_readData, 0);
    check("rst_alu", wb_ALUResult, 0);
    check("rst_wreg", wb_writeReg, 0);
    check("rst_mis", misaligned, 0);
    rst = 1'b0;
    #1;
    check("rst_stall_memop", stall, 1);
    idle();
    check("rst_stall_idle", stall, 0);
    drive(1, 0, 0, 0, 1, 32'd23, 32'd0, 5'd5);
    check("alu_stall", stall, 0);
    tick();
    check("alu_valid", wb_valid, 1);
    check("alu_res", wb_ALUResult, 23);
    check("alu_wreg", wb_writeReg, 5);
    check("alu_rdata", wb_readData, 0);
    check("alu_rw", wb_RegWrite, 1);
    check("alu_stall2", stall, 0);
    idle();
    tick();
    check("bubble_valid", wb_valid, 0);
    check("bubble_alu", wb_ALUResult, 0);
    drive(1, 0, 1, 0, 0, 32'h10, 32'd13, 5'd0);
    access("sw10");
    check("sw10_rdata", wb_readData, 0);
    drive(1, 1, 0, 1, 1, 32'h10, 32'd0, 5'd7);
    access("lw10");
    check("lw10_rdata", wb_readData, 13);
    check("lw10_m2r", wb_MemtoReg, 1);
    check("lw10_wreg", wb_writeReg, 7);
    check("lw10_rw", wb_RegWrite, 1);
    check("lw10_alu", wb_ALUResult, 32'h10);
    idle();
    tick();
    drive(1, 0, 1, 0, 0, 32'h20, 32'hDEAD, 5'd0);
    tick();
    check("rstmid_stall", stall, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_valid", wb_valid, 0);
    idle();
    tick();
    drive(1, 1, 0, 1, 1, 32'h20, 32'd0, 5'd9);
    access("lw20");
    check("lw20_rdata", wb_readData, 0);
    idle();
    tick();
    drive(1, 0, 1, 0, 0, 32'h400, 32'h55, 5'd0);
    access("sw400");
    drive(1, 1, 0, 1, 1, 32'h0, 32'd0, 5'd2);
    access("lw0");
    check("wrap_rdata", wb_readData, 32'h55);
    drive(1, 1, 1, 1, 1, 32'h30, 32'h77, 5'd4);
    access("rw30");
    check("rw30_rdata", wb_readData, 0);
    drive(1, 1, 0, 1, 1, 32'h30, 32'd0, 5'd4);
    access("lw30");
    check("lw30_rdata", wb_readData, 32'h77);
    idle();
    tick();
    drive(1, 1, 0, 1, 1, 32'h13, 32'd0, 5'd6);
`ifdef MEM_MISALIGN_TRAP_EN
    check("mis_stall", stall, 0);
    tick();
    check("mis_flag", misaligned, 1);
    check("mis_valid", wb_valid, 1);
    check("mis_rw", wb_RegWrite, 0);
    check("mis_rdata", wb_readData, 0);
    idle();
    tick();
    check("mis_clear", misaligned, 0);
`else
    access("lw13");
    check("lw13_rdata", wb_readData, 13);
    check("lw13_mis", misaligned, 0);
`endif
    idle();
    tick();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
